// File: rtl/halut_pkg.sv
// halut_pkg: shared defaults and derived widths for the HALUT decoder slice.
//   K             prototypes per codebook (power of 2, >= 2)
//   C             codebooks summed per result (>= 2)
//   M             output columns sharing one index stream (>= 1)
//   DataTypeWidth signed LUT entry width
//   AccWidth      signed accumulator width (>= DataTypeWidth)
// Derived: KAddrWidth, CntWidth, LutAddrWidth, ColWidth, and addr_width(),
// which returns max(1, clog2(n)) for any parameter set.
package halut_pkg;

  localparam int K             = 4;
  localparam int C             = 4;
  localparam int M             = 2;
  localparam int DataTypeWidth = 8;
  localparam int AccWidth      = 9;

  // Minimum one bit, so single-entry fields still get a legal port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KAddrWidth   = addr_width(K);
  localparam int CntWidth     = addr_width(C);
  localparam int LutAddrWidth = addr_width(C * K);
  localparam int ColWidth     = addr_width(M);

endpackage

// File: rtl/scm_multicol.sv
// scm_multicol: latch-free standard-cell style LUT memory, M columns deep Depth.
// One column is written per cycle. All M columns are read together at raddr.
// The read is combinational. A write in the same cycle as a read of that
// address therefore returns the old entry, because the new value lands only
// on the clock edge.
// Ports:
//   clk_i  clock
//   we     write enable
//   waddr  write address
//   wcol   write column
//   wdata  write data
//   raddr  read address
//   rdata  M entries; column j is at rdata[j]
module scm_multicol
  import halut_pkg::*;
#(
  parameter int Depth = C * K,
  parameter int Cols  = M,
  parameter int Width = DataTypeWidth
) (
  input  logic                             clk_i,
  input  logic                             we,
  input  logic [addr_width(Depth)-1:0]     waddr,
  input  logic [addr_width(Cols)-1:0]      wcol,
  input  logic [Width-1:0]                 wdata,
  input  logic [addr_width(Depth)-1:0]     raddr,
  output logic [Cols-1:0][Width-1:0]       rdata
);

  logic [Width-1:0] mem [Cols][Depth];

  // NOTE: storage arrays get no reset, so they map onto plain flops/SRAM
  // cells; the contents are simply undefined until written.
  always_ff @(posedge clk_i) begin
    if (we) mem[wcol][waddr] <= wdata;
  end

  always_comb begin
    for (int j = 0; j < Cols; j++) rdata[j] = mem[j][raddr];
  end

endmodule

// File: rtl/halut_decoder_stream.sv
// halut_decoder_stream: streaming HALUT decoder.
// The input is a stream of prototype indices, one per codebook. For each
// index the block looks up M LUT entries, then adds them across C codebooks.
// Each completed row appears on a valid/ready output.
// Build option: define HALUT_DECODER_SATURATE_EN to make every addition
// saturate. Without it, additions wrap modulo 2^AccWidth.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   we_i/waddr_i/wcol_i/wdata_i  LUT write port; waddr_i = {c, k}
//   clear_i               synchronous abort of the current row
//   in_valid_i/in_ready_o/k_addr_i  index stream for the current codebook
//   out_valid_o/out_ready_i/result_o  row result, column j at [j*AccWidth +: AccWidth]
module halut_decoder_stream
  import halut_pkg::*;
#(
  parameter int K             = halut_pkg::K,
  parameter int C             = halut_pkg::C,
  parameter int M             = halut_pkg::M,
  parameter int DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter int AccWidth      = halut_pkg::AccWidth
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               we_i,
  input  logic [addr_width(C*K)-1:0]         waddr_i,
  input  logic [addr_width(M)-1:0]           wcol_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               clear_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [addr_width(K)-1:0]           k_addr_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [M*AccWidth-1:0]              result_o
);

  localparam int CntW = addr_width(C);

  logic                                 en, hs;
  logic [CntW-1:0]                      c_q;
  logic [M-1:0][DataTypeWidth-1:0]      rdata;
  logic                                 s1_valid_q, s1_last_q;
  logic signed [DataTypeWidth-1:0]      s1_data_q [M];
  logic signed [AccWidth-1:0]           acc_q [M];
  logic signed [AccWidth-1:0]           sum [M];
  logic [M*AccWidth-1:0]                result_q;
  logic                                 out_valid_q;

  assign en          = !out_valid_q || out_ready_i;
  assign hs          = in_valid_i && en;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

  // K is a power of two, so {c, k} equals c*K + k.
  scm_multicol #(.Depth(C * K), .Cols(M), .Width(DataTypeWidth)) u_lut (
    .clk_i (clk_i),
    .we    (we_i),
    .waddr (waddr_i),
    .wcol  (wcol_i),
    .wdata (wdata_i),
    .raddr ({c_q, k_addr_i}),
    .rdata (rdata)
  );

  // Each column adds its sign-extended stage-1 entry to its accumulator.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    for (int j = 0; j < M; j++) begin
`ifdef HALUT_DECODER_SATURATE_EN
      logic signed [AccWidth:0] wide;
      wide = (AccWidth+1)'(acc_q[j]) + (AccWidth+1)'(s1_data_q[j]);
      // The two top bits differ only when the true sum left the AccWidth range.
      if (wide[AccWidth] != wide[AccWidth-1])
        sum[j] = wide[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                : {1'b0, {(AccWidth-1){1'b1}}};
      else
        sum[j] = wide[AccWidth-1:0];
`else
      sum[j] = acc_q[j] + AccWidth'(s1_data_q[j]);
`endif
    end
  end

  // NOTE: all state updates use non-blocking assignments. Every register
  // then samples the values from before the edge, which keeps the pipeline
  // stages independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      for (int j = 0; j < M; j++) begin
        s1_data_q[j] <= '0;
        acc_q[j]     <= '0;
      end
    end else if (clear_i) begin
      // Abort the row. A handshake in the same cycle is dropped.
      c_q         <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < M; j++) acc_q[j] <= '0;
    end else if (en) begin
      s1_valid_q <= hs;
      if (hs) begin
        s1_last_q <= (c_q == CntW'(C - 1));
        c_q       <= (c_q == CntW'(C - 1)) ? '0 : c_q + 1'b1;
        for (int j = 0; j < M; j++) s1_data_q[j] <= rdata[j];
      end
      // While en is high, any result still held has just been accepted.
      // So out_valid follows whether a new row completes this cycle.
      out_valid_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        for (int j = 0; j < M; j++) begin
          if (s1_last_q) begin
            result_q[j*AccWidth +: AccWidth] <= sum[j];
            acc_q[j] <= '0;
          end else begin
            acc_q[j] <= sum[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_halut_decoder_stream.sv
// tb_halut_decoder_stream: scoreboard bench for halut_decoder_stream with
// C=4, K=4, M=2, DataTypeWidth=8, AccWidth=9. Stimulus pushes hand-computed
// row sums into queues. A monitor pops them whenever a result is accepted.
module tb_halut_decoder_stream;

  localparam int NK = 4, NC = 4, NM = 2, DW = 8, AW = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 we;
  logic [3:0]           waddr;
  logic [0:0]           wcol;
  logic [DW-1:0]        wdata;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           k_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [NM*AW-1:0]     result;

  halut_decoder_stream #(
    .K(NK), .C(NC), .M(NM), .DataTypeWidth(DW), .AccWidth(AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .we_i        (we),
    .waddr_i     (waddr),
    .wcol_i      (wcol),
    .wdata_i     (wdata),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .k_addr_i    (k_addr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q0[$];
  int exp_q1[$];
  int pop_times[$];
  int cyc = 0;
  int stalls = 0;
  bit stim_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int col(input int j);
    logic signed [AW-1:0] v;
    v = result[j*AW +: AW];
    return int'(v);
  endfunction

  // Monitor: compare each accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got col0=%0d col1=%0d with empty scoreboard",
                 col(0), col(1));
      end else begin
        check("result_col0", col(0), exp_q0.pop_front());
        check("result_col1", col(1), exp_q1.pop_front());
      end
      pop_times.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All tasks start and end on a falling edge.
  task automatic wr(input int c, input int a, input int d);
    we = 1'b1; wcol = c[0:0]; waddr = a[3:0]; wdata = d[DW-1:0];
    @(negedge clk);
    we = 1'b0;
  endtask

  // Column 0 gets entry 4c+k, which equals the address. Column 1 gets -1.
  task automatic load_seq();
    for (int a = 0; a < NC * NK; a++) begin
      wr(0, a, a);
      wr(1, a, -1);
    end
  endtask

  task automatic send(input int k);
    int n = 0;
    in_valid = 1'b1;
    k_addr   = k[1:0];
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic row(input int k0, input int k1, input int k2, input int k3);
    send(k0); send(k1); send(k2); send(k3);
  endtask

  task automatic expect_row(input int c0, input int c1);
    exp_q0.push_back(c0);
    exp_q1.push_back(c1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q0.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q0.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q0.size());
    end
  endtask

  initial begin
    logic [NM*AW-1:0] snap;
    int n;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wcol = '0; wdata = '0;
    clear = 1'b0; in_valid = 1'b0; k_addr = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_result", int'(result), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    load_seq();

    // Single row with diagonal indices: 0 + 5 + 10 + 15 = 30 and 4 * -1 = -4.
    expect_row(30, -4);
    row(0, 1, 2, 3);
    drain();
    @(negedge clk);
    check("single_cycle_valid", int'(out_valid), 0);

    // Back-to-back rows with no input stall. The second row is
    // 1 + 5 + 9 + 13 = 28. The results come C cycles apart.
    pop_times.delete();
    stalls = 0;
    expect_row(30, -4);
    expect_row(28, -4);
    row(0, 1, 2, 3);
    row(1, 1, 1, 1);
    drain();
    check("b2b_no_stall", stalls, 0);
    check("b2b_result_count", pop_times.size(), 2);
    if (pop_times.size() == 2)
      check("b2b_spacing", pop_times[1] - pop_times[0], NC);

    // Output stall: the held result must not change, and no index is lost.
    out_ready = 1'b0;
    stim_done = 1'b0;
    expect_row(30, -4);
    expect_row(28, -4);
    fork
      begin
        row(0, 1, 2, 3);
        row(1, 1, 1, 1);
        stim_done = 1'b1;
      end
    join_none
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("stall_result_arrives", int'(out_valid), 1);
    snap = result;
    repeat (3) @(negedge clk);
    check("stall_in_ready_low", int'(in_ready), 0);
    check("stall_out_valid_held", int'(out_valid), 1);
    check("stall_result_stable", int'(result == snap), 1);
    out_ready = 1'b1;
    n = 0;
    while (!stim_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("stall_stim_done", int'(stim_done), 1);
    drain();

    // Clear at c=2. The dropped index and the partial row must not leak.
    send(0);
    send(1);
    clear = 1'b1; in_valid = 1'b1; k_addr = 2'd2;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_out_valid", int'(out_valid), 0);
    expect_row(30, -4);
    row(0, 1, 2, 3);
    drain();

    // Reset mid-row, rewrite the LUT, then run a full row.
    send(0);
    send(1);
    rst_n = 1'b0;
    #1;
    check("midrow_reset_out_valid", int'(out_valid), 0);
    check("midrow_reset_result", int'(result), 0);
    check("midrow_reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_seq();
    expect_row(30, -4);
    row(0, 1, 2, 3);
    drain();

    // All entries are 127, so the true sum is 508. The saturating build
    // gives 255; the wrapping build gives 508 - 512 = -4.
    for (int a = 0; a < NC * NK; a++) begin
      wr(0, a, 127);
      wr(1, a, 127);
    end
`ifdef HALUT_DECODER_SATURATE_EN
    expect_row(255, 255);
`else
    expect_row(-4, -4);
`endif
    row(0, 1, 2, 3);
    drain();

    check("scoreboard_empty", exp_q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
